// File: rtl/interrupt_ack_controller.sv
// CPU-side acknowledge engine of the 8259A: raises INT, runs the 2/3-pulse INTA
// sequence, drives CALL/vector bytes and owns the in-service register.
module interrupt_ack_controller #(
   parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode,
   input  logic [7:0] interrupt,
   input  logic       inta_n,
   input  logic       icw1_adi,
   input  logic [2:0] icw1_a7_a5,
   input  logic [7:0] icw2,
   input  logic       auto_eoi,
   input  logic       eoi_pulse,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   output logic       int_out,
   output logic [7:0] data_out,
   output logic       data_out_en,
   output logic [7:0] clear_irr,
   output logic [7:0] in_service_register,
   output logic [7:0] highest_level_in_service
);

   typedef enum logic [2:0] {IDLE, ACK1, WAIT2, ACK2, WAIT3, ACK3} state_t;

   state_t     state_q, state_d;
   logic       inta_d_q;
   logic       int_out_q, int_out_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_en_q, data_en_d;
   logic [7:0] clear_irr_q, clear_irr_d;
   logic [7:0] isr_q, isr_d;
   logic [2:0] level_q, level_d;
   logic       mode_q, mode_d;
   logic       spurious_q, spurious_d;

   logic       inta_fall, inta_rise;
   logic [2:0] req_level;
   logic [7:0] set_mask, aeoi_mask, eoi_mask;
   logic [7:0] vector_byte;
   logic       final_rise;

   assign inta_fall = inta_d_q & ~inta_n;
   assign inta_rise = ~inta_d_q & inta_n;

   // Lowest index wins should the resolver ever hand over more than one bit.
   always_comb begin
      req_level = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (interrupt[i]) req_level = 3'(i);
      end
   end

   always_comb begin
      vector_byte = {icw2[7:3], level_q};
      if (!mode_q) begin
         if (icw1_adi) vector_byte = {icw1_a7_a5, level_q, 2'b00};
         else          vector_byte = {icw1_a7_a5[2:1], level_q, 3'b000};
      end
   end

   always_comb begin
      state_d     = state_q;
      int_out_d   = int_out_q;
      data_out_d  = data_out_q;
      data_en_d   = data_en_q;
      clear_irr_d = 8'h00;
      level_d     = level_q;
      mode_d      = mode_q;
      spurious_d  = spurious_q;
      set_mask    = 8'h00;
      final_rise  = 1'b0;
      case (state_q)
         IDLE: begin
            int_out_d = |interrupt;
            if (inta_fall && int_out_q) begin
               state_d   = ACK1;
               int_out_d = 1'b0;
               mode_d    = mode;
               if (interrupt == 8'h00) begin
                  level_d    = 3'd7;
                  spurious_d = 1'b1;
               end else begin
                  level_d     = req_level;
                  spurious_d  = 1'b0;
                  set_mask    = 8'd1 << req_level;
                  clear_irr_d = 8'd1 << req_level;
               end
               if (mode) begin
                  data_en_d = 1'b0;
               end else begin
                  data_out_d = CALL_OPCODE;
                  data_en_d  = 1'b1;
               end
            end
         end
         ACK1: begin
            if (inta_rise) begin
               state_d   = WAIT2;
               data_en_d = 1'b0;
            end
         end
         WAIT2: begin
            if (inta_fall) begin
               state_d    = ACK2;
               data_out_d = vector_byte;
               data_en_d  = 1'b1;
            end
         end
         ACK2: begin
            if (inta_rise) begin
               data_en_d = 1'b0;
               if (mode_q) begin
                  state_d    = IDLE;
                  final_rise = 1'b1;
               end else begin
                  state_d = WAIT3;
               end
            end
         end
         WAIT3: begin
            if (inta_fall) begin
               state_d    = ACK3;
               data_out_d = icw2;
               data_en_d  = 1'b1;
            end
         end
         ACK3: begin
            if (inta_rise) begin
               state_d    = IDLE;
               data_en_d  = 1'b0;
               final_rise = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Clears apply before sets so a new acknowledge wins over an EOI on the same bit.
   always_comb begin
      aeoi_mask = 8'h00;
      eoi_mask  = 8'h00;
      if (final_rise && auto_eoi && !spurious_q) aeoi_mask = 8'd1 << level_q;
      if (eoi_pulse) begin
         if (eoi_specific) eoi_mask = 8'd1 << eoi_level;
         else              eoi_mask = highest_level_in_service;
      end
      isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         inta_d_q    <= 1'b1;
         int_out_q   <= 1'b0;
         data_out_q  <= 8'h00;
         data_en_q   <= 1'b0;
         clear_irr_q <= 8'h00;
         isr_q       <= 8'h00;
         level_q     <= 3'd0;
         mode_q      <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         inta_d_q    <= inta_n;
         int_out_q   <= int_out_d;
         data_out_q  <= data_out_d;
         data_en_q   <= data_en_d;
         clear_irr_q <= clear_irr_d;
         isr_q       <= isr_d;
         level_q     <= level_d;
         mode_q      <= mode_d;
         spurious_q  <= spurious_d;
      end
   end

   assign int_out                  = int_out_q;
   assign data_out                 = data_out_q;
   assign data_out_en              = data_en_q;
   assign clear_irr                = clear_irr_q;
   assign in_service_register      = isr_q;
   assign highest_level_in_service = isr_q & (~isr_q + 8'd1);

endmodule

// File: doc/interrupt_ack_controller.md
Name: interrupt_ack_controller

Overview:
CPU-facing end of the 8259A interrupt path. It takes the one-hot winning request from the priority resolver and raises INT to the CPU. It then runs the INTA acknowledge sequence (8086: two pulses, 8080: three pulses), drives the vector/CALL bytes onto the data bus, and maintains the in-service register. It also feeds in_service_register and highest_level_in_service back to the resolver and handles EOI and auto-EOI.

Parameters:
CALL_OPCODE, 8'hCD, first byte driven in 8080 mode.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  1 = 8086 (2 INTA pulses), 0 = 8080 (3 INTA pulses); sampled only in IDLE.
interrupt  input  8  one-hot highest-priority unmasked request from resolver; 0 = none.
inta_n  input  1  CPU acknowledge strobe, active low, synchronous to clk.
icw1_adi  input  1  8080 call interval: 1 = 4 bytes, 0 = 8 bytes.
icw1_a7_a5  input  3  8080 low-address bits A7..A5.
icw2  input  8  8086: T7..T3 in [7:3]; 8080: high address byte.
auto_eoi  input  1  ICW4 AEOI.
eoi_pulse  input  1  one-cycle OCW2 EOI command strobe.
eoi_specific  input  1  1 = specific EOI at eoi_level, 0 = non-specific.
eoi_level  input  3  level for specific EOI.
int_out  output  1  INT to CPU, active high.
data_out  output  8  byte driven during INTA.
data_out_en  output  1  data bus drive enable.
clear_irr  output  8  one-cycle one-hot pulse clearing the acknowledged IRR bit.
in_service_register  output  8  ISR.
highest_level_in_service  output  8  one-hot of lowest-index set ISR bit (IR0 highest); 0 if ISR empty.

Behaviour:
- Reset (async, rst_n=0): state IDLE; int_out=0, data_out=0, data_out_en=0, clear_irr=0, ISR=0; inta_n history register=1.
- INTA falling edge = registered inta_n_d==1 && inta_n==0. Rising edge = inta_n_d==0 && inta_n==1.
- States: IDLE, ACK1, WAIT2, ACK2, WAIT3, ACK3.
- IDLE: int_out registered = (interrupt!=0). On falling edge, go to ACK1. A falling edge with int_out=0 is ignored.
- Entering ACK1 (same edge):
  - Latch level = index of interrupt's set bit and latch mode.
  - If interrupt==0 (spurious): level=7, no ISR set, no clear_irr.
  - Otherwise set ISR[level] and pulse clear_irr[level] for one cycle.
  - int_out drops on this edge.
- ACK1:
  - 8086: data_out_en=0.
  - 8080: data_out=CALL_OPCODE, data_out_en=1.
  - On rising edge, go to WAIT2.
- WAIT2: on falling edge, go to ACK2.
- ACK2: data_out_en=1.
  - 8086: data_out = {icw2[7:3], level}.
  - 8080, adi=1: data_out = {icw1_a7_a5, level, 2'b00}.
  - 8080, adi=0: data_out = {icw1_a7_a5[2:1], level, 3'b000}.
  - On rising edge: 8086 returns to IDLE; 8080 goes to WAIT3.
- WAIT3: on falling edge, go to ACK3.
- ACK3: data_out=icw2, data_out_en=1. On rising edge, return to IDLE.
- data_out_en is 0 in IDLE/WAIT states and drops on the rising-edge clock. data_out holds its last value when disabled.
- Auto-EOI: when the final rising edge of the sequence is seen and auto_eoi=1, clear ISR[level] (non-spurious only).
- EOI:
  - Non-specific clears highest_level_in_service bit.
  - Specific clears ISR[eoi_level].
  - EOI on an empty ISR has no effect.
- Same-cycle set and clear: next ISR = (ISR & ~clear_mask) | set_mask, so a set wins on the same bit.
- highest_level_in_service and in_service_register are registered-state-derived; highest_level_in_service is combinational from ISR.
- Reset mid-sequence aborts immediately to IDLE with ISR cleared; no residual drive.
- New requests during a sequence do not affect the latched level. int_out re-evaluates only in IDLE.

Test Plan:
- Reset with inta_n=1, interrupt=8'h04 -> all outputs 0 during reset; after release int_out=1 on next clk.
- 8086, icw2=8'h40, interrupt=8'b00000100, two INTA pulses -> pulse1: data_out_en=0, ISR=8'h04, clear_irr=8'h04 one cycle; pulse2: data_out=8'h42, en=1; state back to IDLE.
- 8080, adi=1, a7_a5=3'b101, icw2=8'h12, interrupt=8'h08 -> bytes 8'hCD, 8'hAC, 8'h12 on three pulses; ISR=8'h08.
- ISR=8'h0A, eoi_pulse non-specific -> ISR=8'h08, highest_level_in_service=8'h08; then specific EOI level 3 -> ISR=0.
- auto_eoi=1, 8086 sequence on IR5 -> ISR[5]=1 during pulses, 0 after second rising edge.
- interrupt goes to 0 before first INTA -> vector {icw2[7:3],3'd7}, ISR unchanged; separately rst_n low during ACK2 -> data_out_en=0 and ISR=0 immediately.
